sum_vector_serializer: RTL

//  Consumer end of the column adder tree. Captures one parallel vector of OUTPUT_SIZE signed

---
 rtl/sum_serializer_pkg.sv | 11 +
 rtl/sum_vector_buffer.sv | 37 +++
 rtl/sum_vector_serializer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/sum_serializer_pkg.sv
// sum_serializer_pkg: shared state type and sizing helper for the sum vector serializer.
package sum_serializer_pkg;

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} ser_state_t;

  // Width of an index into an n-element vector, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sum_vector_buffer.sv
// sum_vector_buffer: one vector of OUTPUT_SIZE signed elements, loaded in parallel,
// read one element at a time through rd_idx. Cleared by the asynchronous active-low reset.
module sum_vector_buffer
  import sum_serializer_pkg::*;
#(
  parameter int WIDTH       = 17,
  parameter int OUTPUT_SIZE = 32,
  localparam int IDX_W      = idx_width(OUTPUT_SIZE)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_en,
  input  logic signed [WIDTH-1:0] load_data [0:OUTPUT_SIZE-1],
  input  logic [IDX_W-1:0]        rd_idx,
  output logic signed [WIDTH-1:0] rd_data
);

  logic signed [WIDTH-1:0] mem [0:OUTPUT_SIZE-1];

  // Capture the whole vector when load_en is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem <= '{default: '0};
    end else if (load_en) begin
      mem <= load_data;
    end
  end

  // Element read; an index past the end (idx+1 on the last element) reads zero.
  always_comb begin
    rd_data = '0;
    if (int'(rd_idx) < OUTPUT_SIZE) begin
      rd_data = mem[rd_idx];
    end
  end

endmodule

// File: rtl/sum_vector_serializer.sv
// sum_vector_serializer: accepts a parallel vector of signed column sums and streams it
// out one element per beat in index order, tagged with its index and a last flag.
// Optional macro SUM_SERIALIZER_DOUBLE_BUFFER_EN adds a pending buffer so a following
// vector can be accepted while the current one drains, removing the inter-vector bubble.
module sum_vector_serializer
  import sum_serializer_pkg::*;
#(
  parameter int WIDTH       = 17,
  parameter int OUTPUT_SIZE = 32,
  localparam int IDX_W      = idx_width(OUTPUT_SIZE)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] in_data [0:OUTPUT_SIZE-1],
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic [IDX_W-1:0]        out_index,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUTPUT_SIZE - 1);
  localparam bit               ONE_ELEM = (OUTPUT_SIZE == 1);

  ser_state_t              state;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        idx_inc;
  logic                    accept;
  logic                    beat;
  logic                    last_beat;
  logic                    reload;
  logic signed [WIDTH-1:0] act_elem;
  logic signed [WIDTH-1:0] first_elem;

  assign accept    = in_valid && in_ready;
  assign beat      = out_valid && out_ready;
  assign last_beat = beat && out_last;
  assign idx_inc   = idx + 1'b1;
  assign out_index = idx;

`ifdef SUM_SERIALIZER_DOUBLE_BUFFER_EN
  // Two ping-pong buffers: sel names the one being drained, the other holds the pending vector.
  logic                    sel;
  logic                    pending_full;
  logic                    act_load;
  logic                    pend_load;
  logic                    b0_load;
  logic                    b1_load;
  logic [IDX_W-1:0]        b0_idx;
  logic [IDX_W-1:0]        b1_idx;
  logic signed [WIDTH-1:0] b0_rd;
  logic signed [WIDTH-1:0] b1_rd;
  logic signed [WIDTH-1:0] pend_elem0;

  // An accept while idle or on the last beat goes straight to the active buffer (bypass).
  assign act_load   = accept && ((state == IDLE) || last_beat);
  assign pend_load  = accept && (state == DRAIN) && !last_beat;
  assign b0_load    = sel ? pend_load : act_load;
  assign b1_load    = sel ? act_load  : pend_load;
  assign b0_idx     = sel ? '0 : idx_inc;
  assign b1_idx     = sel ? idx_inc : '0;
  assign act_elem   = sel ? b1_rd : b0_rd;
  assign pend_elem0 = sel ? b0_rd : b1_rd;
  assign reload     = last_beat && (pending_full || accept);
  assign first_elem = (last_beat && pending_full) ? pend_elem0 : in_data[0];

  sum_vector_buffer #(.WIDTH(WIDTH), .OUTPUT_SIZE(OUTPUT_SIZE)) u_buf0 (
    .clk       (clk),
    .reset     (reset),
    .load_en   (b0_load),
    .load_data (in_data),
    .rd_idx    (b0_idx),
    .rd_data   (b0_rd)
  );

  sum_vector_buffer #(.WIDTH(WIDTH), .OUTPUT_SIZE(OUTPUT_SIZE)) u_buf1 (
    .clk       (clk),
    .reset     (reset),
    .load_en   (b1_load),
    .load_data (in_data),
    .rd_idx    (b1_idx),
    .rd_data   (b1_rd)
  );

  // Pending-slot tracking: swap buffers on the last beat when a vector waits; ready mirrors the free slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel          <= 1'b0;
      pending_full <= 1'b0;
      in_ready     <= 1'b1;
    end else if (last_beat && pending_full) begin
      sel          <= ~sel;
      pending_full <= 1'b0;
      in_ready     <= 1'b1;
    end else if (pend_load) begin
      pending_full <= 1'b1;
      in_ready     <= 1'b0;
    end
  end
`else
  assign reload     = 1'b0;
  assign first_elem = in_data[0];

  sum_vector_buffer #(.WIDTH(WIDTH), .OUTPUT_SIZE(OUTPUT_SIZE)) u_buf0 (
    .clk       (clk),
    .reset     (reset),
    .load_en   (accept),
    .load_data (in_data),
    .rd_idx    (idx_inc),
    .rd_data   (act_elem)
  );

  // Single buffer: ready only while idle, dropping on accept and returning after the last beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready <= 1'b1;
    end else if (accept) begin
      in_ready <= 1'b0;
    end else if (last_beat) begin
      in_ready <= 1'b1;
    end
  end
`endif

  // Control FSM; out_data/out_last/out_valid are loaded with the next beat's values so they come straight from flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= DRAIN;
            idx       <= '0;
            out_valid <= 1'b1;
            out_data  <= first_elem;
            out_last  <= ONE_ELEM;
          end
        end
        DRAIN: begin
          if (beat) begin
            if (!out_last) begin
              idx      <= idx_inc;
              out_data <= act_elem;
              out_last <= (idx_inc == LAST_IDX);
            end else if (reload) begin
              idx      <= '0;
              out_data <= first_elem;
              out_last <= ONE_ELEM;
            end else begin
              state     <= IDLE;
              idx       <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
